msf_frame_decoder: RTL



---
 rtl/msf_pkg.sv | 29 ++
 rtl/msf_bcd_range_check.sv | 25 ++
 rtl/msf_frame_decoder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/msf_pkg.sv
// Shared definitions for the MSF time-code frame decoder.
//   - msf_state_e : decoder FSM states
//   - bit-position constants within the 60-second MSF frame
//   - marker pattern carried on A52..A59 (A52 is the MSB)
//   - msf_dbg_t   : debug view of the FSM and frame accumulators
package msf_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } msf_state_e;

  localparam logic [5:0] HOUR_H_FIRST = 6'd39;
  localparam logic [5:0] MIN_L_LAST   = 6'd51;
  localparam logic [5:0] PAR_HM_B     = 6'd57;
  localparam logic [5:0] MARK_FIRST   = 6'd52;
  localparam logic [5:0] MARK_LAST    = 6'd59;
  localparam logic [5:0] FRAME_LAST   = 6'd59;

  localparam logic [7:0] MARKER_PAT   = 8'b0111_1110;

  typedef struct packed {
    msf_state_e state;    // FSM state
    logic [5:0] count;    // last second received in the current frame
    logic       par;      // running parity over A39..A51 and B57
    logic       mark_ok;  // A52..A59 agree with MARKER_PAT so far
  } msf_dbg_t;

endpackage

// File: rtl/msf_bcd_range_check.sv
// Combinational BCD range validity for an hh:mm time of day.
// Ports:
//   hour_h   in  2  BCD hour tens
//   hour_l   in  4  BCD hour units
//   minute_h in  3  BCD minute tens
//   minute_l in  4  BCD minute units
//   hhmm_ok  out 1  1 when hh is 00..23 and mm is 00..59
module msf_bcd_range_check (
  input  logic [1:0] hour_h,
  input  logic [3:0] hour_l,
  input  logic [2:0] minute_h,
  input  logic [3:0] minute_l,
  output logic       hhmm_ok
);

  logic hour_ok;
  logic minute_ok;

  // Hours 20..23 restrict the units digit further than 00..19 do.
  assign hour_ok   = (hour_h <= 2'd2) && (hour_l <= 4'd9) &&
                     !((hour_h == 2'd2) && (hour_l > 4'd3));
  assign minute_ok = (minute_h <= 3'd5) && (minute_l <= 4'd9);
  assign hhmm_ok   = hour_ok && minute_ok;

endmodule

// File: rtl/msf_frame_decoder.sv
// MSF time-code minute assembler.
// Collects one classified symbol per second, validates the completed frame
// (second count, A52..A59 marker pattern, 57B odd parity, BCD ranges) and, on
// the minute marker closing a good frame, presents hh:mm:00 with a load pulse.
//
// Handshake: sym_valid_i is a single-cycle strobe with no back-pressure; the
// symbol fields are sampled only in that cycle. load_o / frame_err_o are
// single-cycle pulses one cycle after the closing strobe; the *_load_o values
// are valid while load_o is high and hold until the next good frame.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   sym_valid_i              symbol strobe (one per second)
//   sym_minute_i             symbol is the minute marker
//   sym_a_i, sym_b_i         A/B bits of a non-marker symbol
//   load_o                   good frame closed, load values valid
//   hour_h/l_load_o          BCD hour tens/units
//   minute_h/l_load_o        BCD minute tens/units
//   second_h/l_load_o        always 0 (load happens at second 00)
//   locked_o                 last closed frame was good
//   frame_err_o              frame rejected
//   dbg_o                    FSM state and frame accumulators
module msf_frame_decoder
  import msf_pkg::*;
#(
  parameter bit CHECK_PARITY = 1'b1,
  parameter bit CHECK_MARKER = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sym_valid_i,
  input  logic       sym_minute_i,
  input  logic       sym_a_i,
  input  logic       sym_b_i,
  output logic       load_o,
  output logic [1:0] hour_h_load_o,
  output logic [3:0] hour_l_load_o,
  output logic [2:0] minute_h_load_o,
  output logic [3:0] minute_l_load_o,
  output logic [2:0] second_h_load_o,
  output logic [3:0] second_l_load_o,
  output logic       locked_o,
  output logic       frame_err_o,
  output msf_dbg_t   dbg_o
);

  msf_state_e  state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [12:0] hm_sr_q;
  logic        par_q;
  logic        mark_ok_q;

  logic        data_stb;
  logic        marker_stb;
  logic [5:0]  pos;
  logic        in_hm;
  logic        in_mark;
  logic [5:0]  mark_off;
  logic [2:0]  mark_idx;
  logic        bcd_ok;
  logic        frame_ok;

  logic        do_load;
  logic        do_err;
  logic        clear_frame;
  logic        capture;

  assign data_stb   = sym_valid_i && !sym_minute_i;
  assign marker_stb = sym_valid_i &&  sym_minute_i;

  // Second number of the symbol currently being strobed.
  assign pos      = count_q + 6'd1;
  assign in_hm    = (pos >= HOUR_H_FIRST) && (pos <= MIN_L_LAST);
  assign in_mark  = (pos >= MARK_FIRST) && (pos <= MARK_LAST);
  // A52 maps to MARKER_PAT[7], A59 to MARKER_PAT[0].
  assign mark_off = MARK_LAST - pos;
  assign mark_idx = mark_off[2:0];

  // Shift register holds A39..A51 with A39 at bit 12.
  msf_bcd_range_check u_range (
    .hour_h   (hm_sr_q[12:11]),
    .hour_l   (hm_sr_q[10:7]),
    .minute_h (hm_sr_q[6:4]),
    .minute_l (hm_sr_q[3:0]),
    .hhmm_ok  (bcd_ok)
  );

  assign frame_ok = (count_q == FRAME_LAST) && bcd_ok &&
                    (par_q || !CHECK_PARITY) &&
                    (mark_ok_q || !CHECK_MARKER);

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HUNT;
      count_q <= 6'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // FSM next state and per-strobe actions
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    do_load     = 1'b0;
    do_err      = 1'b0;
    clear_frame = 1'b0;
    capture     = 1'b0;
    case (state_q)
      HUNT: begin
        if (marker_stb) begin
          state_d     = COLLECT;
          count_d     = 6'd0;
          clear_frame = 1'b1;
        end
      end
      COLLECT: begin
        if (marker_stb) begin
          // Every marker resyncs, whatever the verdict on the frame it closes.
          count_d     = 6'd0;
          clear_frame = 1'b1;
          if (frame_ok) do_load = 1'b1;
          else          do_err  = 1'b1;
        end else if (data_stb) begin
          if (count_q == FRAME_LAST) begin
            // A 60th data symbol means the marker was missed.
            state_d     = HUNT;
            count_d     = 6'd0;
            clear_frame = 1'b1;
            do_err      = 1'b1;
          end else begin
            count_d = pos;
            capture = 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Frame accumulators and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hm_sr_q         <= 13'd0;
      par_q           <= 1'b0;
      mark_ok_q       <= 1'b1;
      load_o          <= 1'b0;
      frame_err_o     <= 1'b0;
      locked_o        <= 1'b0;
      hour_h_load_o   <= 2'd0;
      hour_l_load_o   <= 4'd0;
      minute_h_load_o <= 3'd0;
      minute_l_load_o <= 4'd0;
    end else begin
      load_o      <= do_load;
      frame_err_o <= do_err;

      if (clear_frame) begin
        hm_sr_q   <= 13'd0;
        par_q     <= 1'b0;
        mark_ok_q <= 1'b1;
      end else if (capture) begin
        if (in_hm) hm_sr_q <= {hm_sr_q[11:0], sym_a_i};
        par_q <= par_q ^ (in_hm && sym_a_i) ^ ((pos == PAR_HM_B) && sym_b_i);
        if (in_mark && (sym_a_i != MARKER_PAT[mark_idx])) mark_ok_q <= 1'b0;
      end

      if (do_load) begin
        locked_o        <= 1'b1;
        hour_h_load_o   <= hm_sr_q[12:11];
        hour_l_load_o   <= hm_sr_q[10:7];
        minute_h_load_o <= hm_sr_q[6:4];
        minute_l_load_o <= hm_sr_q[3:0];
      end else if (do_err) begin
        locked_o <= 1'b0;
      end
    end
  end

  assign second_h_load_o = 3'd0;
  assign second_l_load_o = 4'd0;

  assign dbg_o = '{state: state_q, count: count_q, par: par_q, mark_ok: mark_ok_q};

endmodule
